// File: rtl/seq_divider_nb_pkg.sv
// Shared encodings for the iterative RV32M divider.
// Op codes, FSM states and small op-decode helpers.
package seq_divider_nb_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_DIV  = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

  function automatic logic op_is_signed(
    input logic [1:0] op
  );
    return (op == DIV_OP_DIV) ||
           (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(
    input logic [1:0] op
  );
    return (op == DIV_OP_REM) ||
           (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/ripple_carry_adder_Nb.sv
// N-bit ripple-carry adder; inv_b=1 turns it into a - b.
// Ports: a, b, ci, inv_b in; sum, co out (co=1 => a >= b when subtracting).
module ripple_carry_adder_Nb #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         inv_b,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N-1:0] bx;
  logic         cy;

  assign bx = b ^ {N{inv_b}};

  always_comb begin
    sum = '0;
    cy  = ci | inv_b;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ bx[i] ^ cy;
      cy     = (a[i] & bx[i]) |
               (cy & (a[i] ^ bx[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/seq_divider_nb.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, WIDTH+1 cycles.
// Ports: clk_i, rstn_i, start_i, op_i, dividend_i, divisor_i -> ready_o, done_o, result_o.
import seq_divider_nb_pkg::*;

module seq_divider_nb #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [1:0]       op_q;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             in_signed;
  logic             in_zero;
  logic             dd_neg;
  logic             ds_neg;
  logic [WIDTH-1:0] dd_abs;
  logic [WIDTH-1:0] ds_abs;

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   add_sum;
  logic             add_co;
  logic             unused_msb;

  logic [WIDTH-1:0] fix_val;
  logic             fix_neg;
  logic [WIDTH-1:0] fix_res;

  assign ready_o = (state == ST_IDLE);

  assign in_signed = op_is_signed(op_i);
  assign in_zero   = (divisor_i == '0);
  assign dd_neg    = in_signed & dividend_i[WIDTH-1];
  assign ds_neg    = in_signed & divisor_i[WIDTH-1];

  // Divide-by-zero keeps the raw dividend so the remainder
  // comes out as dividend_i with no sign fix.
  assign dd_abs = (dd_neg & ~in_zero) ?
                  (~dividend_i + ONE) : dividend_i;
  assign ds_abs = ds_neg ?
                  (~divisor_i + ONE) : divisor_i;

  assign fix_val = op_is_rem(op_q) ? rem : quo;
  assign fix_neg = op_is_rem(op_q) ? neg_r : neg_q;

  // One adder: trial subtract in DIV, 0 - value in FIX.
  always_comb begin
    add_a = {rem, quo[WIDTH-1]};
    add_b = {1'b0, dvs};
    if (state == ST_FIX) begin
      add_a = '0;
      add_b = {1'b0, fix_val};
    end
  end

  ripple_carry_adder_Nb #(
    .N (WIDTH + 1)
  ) u_add (
    .a     (add_a),
    .b     (add_b),
    .ci    (1'b0),
    .inv_b (1'b1),
    .sum   (add_sum),
    .co    (add_co)
  );

  assign unused_msb = add_sum[WIDTH];

  assign fix_res = fix_neg ?
                   add_sum[WIDTH-1:0] : fix_val;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            quo      <= dd_abs;
            rem      <= '0;
            dvs      <= ds_abs;
            div_zero <= in_zero;
            neg_q    <= (dd_neg ^ ds_neg) & ~in_zero;
            neg_r    <= dd_neg & ~in_zero;
            count    <= CW'(WIDTH - 1);
            state    <= ST_DIV;
          end
        end
        ST_DIV: begin
          rem <= add_co ? add_sum[WIDTH-1:0] :
                          add_a[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], add_co};
          if (count == '0) begin
            state <= ST_FIX;
          end else begin
            count <= count - CW'(1);
          end
        end
        ST_FIX: begin
          result_o <= fix_res;
          done_o   <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_nb.sv
// Self-checking bench for seq_divider_nb.
// Directed spec cases, protocol scenarios and randomized ops vs a model.
module tb_seq_divider_nb;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] dd = '0;
  logic [31:0] ds = '0;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_divider_nb #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dd),
    .divisor_i  (ds),
    .ready_o    (ready),
    .done_o     (done),
    .result_o   (result)
  );

  function automatic logic [31:0] ref_div(
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      if (o == OP_DIV || o == OP_DIVU) return 32'hFFFF_FFFF;
      return a;
    end
    case (o)
      OP_DIVU: return a / b;
      OP_REMU: return a % b;
      OP_DIV:  begin r = sa / sb; return r[31:0]; end
      default: begin r = sa % sb; return r[31:0]; end
    endcase
  endfunction

  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] res
  );
    @(negedge clk);
    op = o; dd = a; ds = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 100);
    res = result;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #2;
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL reset: ready=%b done=%b result=%h want 1 0 0",
               ready, done, result);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [14] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM,
                              OP_DIVU, OP_REMU, OP_DIV, OP_REM,
                              OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV};
    logic [31:0] as  [14] = '{32'd100, 32'd100, -32'sd7, -32'sd7, 32'd7,
                              32'd5, 32'd5, -32'sd5, -32'sd5,
                              32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] bs  [14] = '{32'd7, 32'd7, 32'd2, 32'd2, -32'sd2,
                              32'd0, 32'd0, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd1, 32'hFFFF_FFFF, -32'sd2};
    logic [31:0] ex  [14] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF,
                              32'hFFFF_FFFB, 32'h8000_0000, 32'd0,
                              32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFD};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 14; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, LAT);
      end
      total++;
      if (res !== ex[i]) begin
        bad++;
        $display("FAIL directed[%0d] op=%0d %h/%h: got %h want %h",
                 i, ops[i], as[i], bs[i], res, ex[i]);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    op = OP_DIVU; dd = 32'd1000; ds = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      op = 2'($urandom_range(0, 3));
      dd = $urandom;
      ds = $urandom;
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 100);
    start = 1'b0;
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL busy_ignore latency: got %0d want %0d", lat, LAT);
    end
    total++;
    if (result !== 32'd100) begin
      bad++;
      $display("FAIL busy_ignore result: got %h want %h", result, 32'd100);
    end
    @(posedge clk); #1;
    total++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore idle: ready=%b done=%b want 1 0", ready, done);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] res;
    run_op(OP_DIV, -32'sd100, 32'd9, lat, res);
    total++;
    if (res !== 32'hFFFF_FFF5) begin
      bad++;
      $display("FAIL b2b first: got %h want %h", res, 32'hFFFF_FFF5);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b ready in done cycle: got %b want 1", ready);
    end
    op = OP_REM; dd = -32'sd100; ds = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL b2b done repeat: got %b want 0", done);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 100);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL b2b second latency: got %0d want %0d", lat, LAT);
    end
    total++;
    if (result !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL b2b second: got %h want %h", result, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    int lat;
    logic [31:0] res;
    @(negedge clk);
    op = OP_DIVU; dd = 32'hFFFF_FFFF; ds = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1 || result !== 32'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b result=%h done=%b want 1 0 0",
               ready, result, done);
    end
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL reset_mid stray done: got %0d pulses want 0", pulses);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, lat, res);
    total++;
    if (res !== 32'd3 || lat !== LAT) begin
      bad++;
      $display("FAIL reset_mid next op: got %h lat %0d want 3 lat %0d",
               res, lat, LAT);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    int lat;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_v;
    logic [31:0] res;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick($urandom_range(1, 8));
      b = pick($urandom_range(0, 8));
      exp_v = ref_div(o, a, b);
      run_op(o, a, b, lat, res);
      total++;
      if (res !== exp_v || lat !== LAT) begin
        bad++;
        $display("FAIL random[%0d] op=%0d %h/%h: got %h lat %0d want %h lat %0d",
                 i, o, a, b, res, lat, exp_v, LAT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
